// File: rtl/conv_encoder_214.sv
// conv_encoder_214: rate-1/2, K=4 convolutional encoder (G0=17, G1=15 octal).
// Shifts a MSG_W-bit message out MSB first, one 2-bit symbol per clock,
// and assembles the full 2*MSG_W-bit codeword for the Viterbi decoder.
// Optional feature macro: ENC_TAIL_EN (zero-tail termination; the last three
// message bits are forced to 0 so every word ends in encoder state 000).
module conv_encoder_214 #(
    parameter int unsigned MSG_W = 7,
    parameter logic [3:0]  G0    = 4'b1111,
    parameter logic [3:0]  G1    = 4'b1101
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [MSG_W-1:0]     msg,
    output logic                 busy,
    output logic [1:0]           sym,
    output logic                 sym_valid,
    output logic [2*MSG_W-1:0]   code,
    output logic                 done
);

    localparam int unsigned MEM_W  = 3;
    localparam int unsigned CODE_W = 2 * MSG_W;
    localparam int unsigned CNT_W  = (MSG_W > 1) ? $clog2(MSG_W) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        ENC  = 1'b1
    } state_e;

    state_e              state_q;
    logic [MSG_W-1:0]    msg_q;
    logic [MEM_W-1:0]    enc_q;      // {s1, s2, s3}, s1 = most recent bit
    logic [CNT_W-1:0]    cnt_q;
    logic                busy_q;
    logic [1:0]          sym_q;
    logic                sym_valid_q;
    logic [CODE_W-1:0]   code_q;
    logic                done_q;

    logic                u_c;
    logic [MEM_W:0]      reg4_c;
    logic [1:0]          sym_d;
    logic                last_c;
    logic [MSG_W-1:0]    msg_load_c;

    // Encoder datapath: current bit plus memory against both generators
    always_comb begin
        u_c    = msg_q[MSG_W-1];
        reg4_c = {u_c, enc_q};
        sym_d  = {^(reg4_c & G0), ^(reg4_c & G1)};
        last_c = (cnt_q == CNT_W'(MSG_W - 1));
`ifdef ENC_TAIL_EN
        msg_load_c = {msg[MSG_W-1:MEM_W], MEM_W'(0)};
`else
        msg_load_c = msg;
`endif
    end

    // Control FSM and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            msg_q       <= '0;
            enc_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            sym_q       <= 2'b00;
            sym_valid_q <= 1'b0;
            code_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            sym_valid_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        msg_q   <= msg_load_c;
                        enc_q   <= '0;
                        code_q  <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ENC;
                    end
                end
                ENC: begin
                    sym_q       <= sym_d;
                    sym_valid_q <= 1'b1;
                    code_q      <= {code_q[CODE_W-3:0], sym_d};
                    enc_q       <= {u_c, enc_q[MEM_W-1:1]};
                    msg_q       <= {msg_q[MSG_W-2:0], 1'b0};
                    cnt_q       <= cnt_q + CNT_W'(1);
                    if (last_c) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign sym       = sym_q;
    assign sym_valid = sym_valid_q;
    assign code      = code_q;
    assign done      = done_q;

endmodule
